// File: rtl/hazard_unit_mc.sv
// Hazard unit for a 5-stage F/D/E/M/W pipeline with a multi-cycle MUL/DIV scoreboard.
// Latency: forwarding, stall and flush outputs are combinational; McBusy/McDone/McDest come from state.
// Backpressure: StallF/StallD hold the front end on load-use or multi-cycle hazards; a taken branch overrides stalls.
//
// Ports:
//   CLK, RESETn              clock (rising edge), asynchronous active-low reset
//   RAD, RDUsedD, MCReqD     D-stage source addresses, used-operand mask, multi-cycle request
//   RAE, WA3E, RegWriteE, MemtoRegE, PCSrcE, MCStartE   E-stage sources/destination/controls
//   WA3M, RegWriteM, MemWriteM, RA2M                     M-stage destination/controls/store source
//   WA3W, RegWriteW, MemtoRegW                           W-stage destination/controls
//   StallF, StallD, FlushD, FlushE                       pipeline control
//   ForwardE (2 bits per slot: 00 regfile, 01 W, 10 M), ForwardM (W-to-M store data)
//   McBusy, McDone, McDest                               multi-cycle scoreboard status
//   StallCnt, FlushCnt                                   performance counters
//
// Optional build macro: HAZ_PERF_CNT_EN enables the saturating StallCnt/FlushCnt counters;
// without it both outputs are tied to zero and no counter flops exist.
module hazard_unit_mc #(
    parameter int REG_AW    = 4,
    parameter int NUM_RD    = 3,
    parameter int MC_LAT    = 4,
    parameter int NOFWD_REG = 15
) (
    input  logic                     CLK,
    input  logic                     RESETn,
    input  logic [NUM_RD*REG_AW-1:0] RAD,
    input  logic [NUM_RD-1:0]        RDUsedD,
    input  logic                     MCReqD,
    input  logic [NUM_RD*REG_AW-1:0] RAE,
    input  logic [REG_AW-1:0]        WA3E,
    input  logic                     RegWriteE,
    input  logic                     MemtoRegE,
    input  logic                     PCSrcE,
    input  logic                     MCStartE,
    input  logic [REG_AW-1:0]        WA3M,
    input  logic                     RegWriteM,
    input  logic                     MemWriteM,
    input  logic [REG_AW-1:0]        RA2M,
    input  logic [REG_AW-1:0]        WA3W,
    input  logic                     RegWriteW,
    input  logic                     MemtoRegW,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic [2*NUM_RD-1:0]      ForwardE,
    output logic                     ForwardM,
    output logic                     McBusy,
    output logic                     McDone,
    output logic [REG_AW-1:0]        McDest,
    output logic [31:0]              StallCnt,
    output logic [31:0]              FlushCnt
);

    localparam int CW = $clog2(MC_LAT + 1);

    // The PC register is never a forwarding or hazard candidate.
    function automatic logic addr_match(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
        return (src == dst) && (src != REG_AW'(NOFWD_REG));
    endfunction

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REG_AW-1:0] dest_q, dest_d;

    logic ld_hit, mc_hit, ld_stall, mc_stall, stall;

    // Scoreboard next state. A start arriving on the final busy cycle reloads
    // the counter so a dependent multi-cycle op can issue back-to-back.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dest_d  = dest_q;
        case (state_q)
            S_IDLE: begin
                if (MCStartE) begin
                    state_d = S_BUSY;
                    cnt_d   = CW'(MC_LAT);
                    dest_d  = WA3E;
                end
            end
            S_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    if (MCStartE) begin
                        cnt_d  = CW'(MC_LAT);
                        dest_d = WA3E;
                    end else begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
        end
    end

    assign McBusy = (state_q == S_BUSY);
    assign McDone = McBusy && (cnt_q == CW'(1));
    assign McDest = dest_q;

    // Per-slot forwarding selects (M wins over W) and D-stage hazard hits.
    always_comb begin
        ForwardE = '0;
        ld_hit   = 1'b0;
        mc_hit   = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (RegWriteM && addr_match(RAE[i*REG_AW +: REG_AW], WA3M)) begin
                ForwardE[2*i +: 2] = 2'b10;
            end else if (RegWriteW && addr_match(RAE[i*REG_AW +: REG_AW], WA3W)) begin
                ForwardE[2*i +: 2] = 2'b01;
            end
            if (RDUsedD[i] && addr_match(RAD[i*REG_AW +: REG_AW], WA3E)) begin
                ld_hit = 1'b1;
            end
            if (RDUsedD[i] && addr_match(RAD[i*REG_AW +: REG_AW], dest_q)) begin
                mc_hit = 1'b1;
            end
        end
    end

    assign ForwardM = MemWriteM && RegWriteW && MemtoRegW && addr_match(RA2M, WA3W);

    assign ld_stall = MemtoRegE && RegWriteE && ld_hit;
    // Structural stall on any new multi-cycle request, RAW stall on the pending destination.
    assign mc_stall = McBusy && (MCReqD || mc_hit);
    assign stall    = ld_stall || mc_stall;

    // A taken branch wins: the front end must not hold so the PC takes the target.
    assign StallF = stall && !PCSrcE;
    assign StallD = stall && !PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = stall || PCSrcE;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Saturating counters so a long run never wraps back to small values.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallD && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (FlushD && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Testbench for hazard_unit_mc: directed scenarios followed by randomized traffic.
// Expected outputs come from a cycle-indexed reference model and are queued per cycle.
// A monitor on the falling edge pops each expectation and compares it with the DUT.
module tb_hazard_unit_mc;

    localparam int AW    = 4;
    localparam int NR    = 3;
    localparam int LAT   = 4;
    localparam int NOFWD = 15;
`ifdef HAZ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            CLK, RESETn;
    logic [NR*AW-1:0] RAD, RAE;
    logic [NR-1:0]   RDUsedD;
    logic            MCReqD, RegWriteE, MemtoRegE, PCSrcE, MCStartE;
    logic [AW-1:0]   WA3E, WA3M, RA2M, WA3W;
    logic            RegWriteM, MemWriteM, RegWriteW, MemtoRegW;
    logic            StallF, StallD, FlushD, FlushE, ForwardM, McBusy, McDone;
    logic [2*NR-1:0] ForwardE;
    logic [AW-1:0]   McDest;
    logic [31:0]     StallCnt, FlushCnt;

    hazard_unit_mc #(.REG_AW(AW), .NUM_RD(NR), .MC_LAT(LAT), .NOFWD_REG(NOFWD)) dut (
        .CLK(CLK), .RESETn(RESETn), .RAD(RAD), .RDUsedD(RDUsedD), .MCReqD(MCReqD),
        .RAE(RAE), .WA3E(WA3E), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .PCSrcE(PCSrcE), .MCStartE(MCStartE), .WA3M(WA3M), .RegWriteM(RegWriteM),
        .MemWriteM(MemWriteM), .RA2M(RA2M), .WA3W(WA3W), .RegWriteW(RegWriteW),
        .MemtoRegW(MemtoRegW), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
        .FlushE(FlushE), .ForwardE(ForwardE), .ForwardM(ForwardM), .McBusy(McBusy),
        .McDone(McDone), .McDest(McDest), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit         rstn;
        logic [3:0] rad [NR];
        logic [3:0] rae [NR];
        logic [2:0] used;
        bit         mcreq, rwe, m2re, pcsrc, mcstart, rwm, mwm, rww, m2rw;
        logic [3:0] wa3e, wa3m, ra2m, wa3w;
    } stim_t;

    typedef struct packed {
        int          cyc;
        logic        stallf, stalld, flushd, flushe, fwdm, busy, done;
        logic [5:0]  fwde;
        logic [3:0]  dest;
        logic [31:0] scnt, fcnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: the op in flight occupies cycles up to and including end_cyc.
    int          cyc     = 0;
    int          end_cyc = -1;
    logic [3:0]  m_dest  = 4'd0;
    logic [31:0] m_scnt  = 32'd0;
    logic [31:0] m_fcnt  = 32'd0;

    function automatic bit hit(input logic [3:0] src, input logic [3:0] dst);
        return (int'(src) != NOFWD) && (src == dst);
    endfunction

    function automatic stim_t idle_stim();
        stim_t s;
        s.rstn = 1'b1;
        for (int i = 0; i < NR; i++) begin
            s.rad[i] = 4'd0;
            s.rae[i] = 4'd0;
        end
        s.used = 3'b000; s.mcreq = 0; s.rwe = 0; s.m2re = 0; s.pcsrc = 0; s.mcstart = 0;
        s.rwm = 0; s.mwm = 0; s.rww = 0; s.m2rw = 0;
        s.wa3e = 4'd0; s.wa3m = 4'd0; s.ra2m = 4'd0; s.wa3w = 4'd0;
        return s;
    endfunction

    function automatic logic [3:0] rnd_addr();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r + 4);
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s = idle_stim();
        s.rstn = ($urandom_range(0, 199) != 0);
        for (int i = 0; i < NR; i++) begin
            s.rad[i] = rnd_addr();
            s.rae[i] = rnd_addr();
        end
        s.used = 3'($urandom_range(0, 7));
        s.mcreq = ($urandom_range(0, 3) == 0);
        s.rwe = $urandom_range(0, 1); s.m2re = $urandom_range(0, 1);
        s.pcsrc = ($urandom_range(0, 7) == 0);
        s.mcstart = ($urandom_range(0, 3) == 0);
        s.rwm = $urandom_range(0, 1); s.mwm = $urandom_range(0, 1);
        s.rww = $urandom_range(0, 1); s.m2rw = $urandom_range(0, 1);
        s.wa3e = rnd_addr(); s.wa3m = rnd_addr(); s.ra2m = rnd_addr(); s.wa3w = rnd_addr();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        RESETn = s.rstn;
        for (int i = 0; i < NR; i++) begin
            RAD[i*AW +: AW] = s.rad[i];
            RAE[i*AW +: AW] = s.rae[i];
        end
        RDUsedD = s.used; MCReqD = s.mcreq; RegWriteE = s.rwe; MemtoRegE = s.m2re;
        PCSrcE = s.pcsrc; MCStartE = s.mcstart; WA3E = s.wa3e;
        WA3M = s.wa3m; RegWriteM = s.rwm; MemWriteM = s.mwm; RA2M = s.ra2m;
        WA3W = s.wa3w; RegWriteW = s.rww; MemtoRegW = s.m2rw;
    endtask

    // One pipeline cycle: drive, predict the cycle's outputs, then advance the model past the closing edge.
    task automatic drive(input stim_t s);
        exp_t e;
        bit   ld, raw, busy, stall;
        @(posedge CLK);
        #1;
        cyc++;
        apply(s);
        if (!s.rstn) begin
            end_cyc = -1;
            m_dest  = 4'd0;
            m_scnt  = 32'd0;
            m_fcnt  = 32'd0;
        end
        ld  = 0;
        raw = 0;
        for (int i = 0; i < NR; i++) begin
            if (s.used[i] && hit(s.rad[i], s.wa3e)) ld = 1;
            if (s.used[i] && hit(s.rad[i], m_dest)) raw = 1;
        end
        ld    = ld && s.m2re && s.rwe;
        busy  = (cyc <= end_cyc);
        stall = ld || (busy && (s.mcreq || raw));
        e.cyc    = cyc;
        e.busy   = busy;
        e.done   = busy && (cyc == end_cyc);
        e.dest   = m_dest;
        e.stallf = stall && !s.pcsrc;
        e.stalld = stall && !s.pcsrc;
        e.flushd = s.pcsrc;
        e.flushe = stall || s.pcsrc;
        e.fwdm   = s.mwm && s.rww && s.m2rw && hit(s.ra2m, s.wa3w);
        for (int i = 0; i < NR; i++) begin
            if (s.rwm && hit(s.rae[i], s.wa3m))      e.fwde[2*i +: 2] = 2'b10;
            else if (s.rww && hit(s.rae[i], s.wa3w)) e.fwde[2*i +: 2] = 2'b01;
            else                                     e.fwde[2*i +: 2] = 2'b00;
        end
        e.scnt = PERF ? m_scnt : 32'd0;
        e.fcnt = PERF ? m_fcnt : 32'd0;
        exp_q.push_back(e);
        if (s.rstn) begin
            // A new op is taken when idle or on the last busy cycle of the current one.
            if (s.mcstart && cyc >= end_cyc) begin
                end_cyc = cyc + LAT;
                m_dest  = s.wa3e;
            end
            if (e.stalld && m_scnt != 32'hFFFF_FFFF) m_scnt++;
            if (e.flushd && m_fcnt != 32'hFFFF_FFFF) m_fcnt++;
        end
    endtask

    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("StallF",   e.cyc, 32'(StallF),   32'(e.stallf));
                chk("StallD",   e.cyc, 32'(StallD),   32'(e.stalld));
                chk("FlushD",   e.cyc, 32'(FlushD),   32'(e.flushd));
                chk("FlushE",   e.cyc, 32'(FlushE),   32'(e.flushe));
                chk("ForwardE", e.cyc, 32'(ForwardE), 32'(e.fwde));
                chk("ForwardM", e.cyc, 32'(ForwardM), 32'(e.fwdm));
                chk("McBusy",   e.cyc, 32'(McBusy),   32'(e.busy));
                chk("McDone",   e.cyc, 32'(McDone),   32'(e.done));
                chk("McDest",   e.cyc, 32'(McDest),   32'(e.dest));
                chk("StallCnt", e.cyc, StallCnt,      e.scnt);
                chk("FlushCnt", e.cyc, FlushCnt,      e.fcnt);
            end
        end
    end

    initial begin : stimulus
        stim_t s;
        int    wait_cyc;
        apply(idle_stim());
        RESETn = 1'b0;

        // Reset state.
        s = idle_stim(); s.rstn = 0;
        repeat (2) drive(s);

        // Forwarding: M over W, W alone, PC never forwarded.
        s = idle_stim();
        s.rae[0] = 4'd3; s.wa3m = 4'd3; s.rwm = 1; s.wa3w = 4'd3; s.rww = 1;
        drive(s);
        s.rwm = 0;
        drive(s);
        s.rae[0] = 4'd15; s.wa3m = 4'd15; s.rwm = 1; s.wa3w = 4'd15;
        drive(s);
        // Store-data forward.
        s = idle_stim();
        s.mwm = 1; s.rww = 1; s.m2rw = 1; s.ra2m = 4'd6; s.wa3w = 4'd6;
        drive(s);

        // Load-use on a used slot, then the same address on an unused slot.
        s = idle_stim();
        s.m2re = 1; s.rwe = 1; s.wa3e = 4'd5; s.rad[1] = 4'd5; s.used = 3'b010;
        drive(s);
        s.used = 3'b001;
        drive(s);

        // Branch overrides a load-use stall.
        s.used = 3'b010; s.pcsrc = 1;
        drive(s);

        // Multi-cycle RAW on R7.
        s = idle_stim(); s.mcstart = 1; s.wa3e = 4'd7;
        drive(s);
        s = idle_stim(); s.rad[0] = 4'd7; s.used = 3'b001;
        repeat (6) drive(s);

        // Structural stall, ignored start while busy, back-to-back start on the last busy cycle.
        s = idle_stim(); s.mcstart = 1; s.wa3e = 4'd9;
        drive(s);
        s = idle_stim(); s.mcreq = 1;
        drive(s);
        s.mcstart = 1; s.wa3e = 4'd11;
        drive(s);
        s.mcstart = 0;
        drive(s);
        s = idle_stim(); s.mcstart = 1; s.wa3e = 4'd10;
        drive(s);
        s = idle_stim(); s.rad[2] = 4'd10; s.used = 3'b100;
        repeat (6) drive(s);

        // Reset while two busy cycles remain, then three load-use stalls for the counter.
        s = idle_stim(); s.mcstart = 1; s.wa3e = 4'd4;
        drive(s);
        s = idle_stim();
        repeat (2) drive(s);
        s.rstn = 0;
        drive(s);
        s.rstn = 1;
        repeat (4) drive(s);
        s.m2re = 1; s.rwe = 1; s.wa3e = 4'd5; s.rad[0] = 4'd5; s.used = 3'b001;
        repeat (3) drive(s);
        s = idle_stim();
        repeat (2) drive(s);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) drive(rnd_stim());

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(posedge CLK);
            wait_cyc++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
